// File: rtl/pattern_match_ctrl_if.sv
// Handshake and result bundle between a symbol source/controller and pattern_match_ctrl.
// The source drives run control and the symbol stream; the matcher reports status and results.
interface pattern_match_ctrl_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 4
);
    logic                   start;
    logic [2*PAT_LEN-1:0]   pattern;
    logic                   stop;
    logic                   in_valid;
    logic [1:0]             in_sym;
    logic                   in_ready;
    logic                   busy;
    logic                   found;
    logic [CNT_W-1:0]       match_cnt;
    logic                   done;

    modport master (
        output start, pattern, stop, in_valid, in_sym,
        input  in_ready, busy, found, match_cnt, done
    );

    modport slave (
        input  start, pattern, stop, in_valid, in_sym,
        output in_ready, busy, found, match_cnt, done
    );
endinterface

// File: rtl/pattern_match_ctrl.sv
// Streaming matcher: counts non-overlapping occurrences of a captured 2-bit symbol pattern
// in a valid/ready symbol stream, between a start and a stop.
module pattern_match_ctrl #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pattern_match_ctrl_if.slave   bus
);

    localparam int                IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [2*PAT_LEN-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   found_q, found_d;
    logic                   done_q, done_d;
    logic [1:0]             expected_sym;

    always_comb begin
        expected_sym = 2'b00;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                expected_sym = pat_q[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        found_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (bus.in_valid) begin
                    if (bus.in_sym == expected_sym) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            found_d = 1'b1;
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    // A broken partial match may still be the first symbol of a new one
                    end else if ((idx_q != '0) && (bus.in_sym == pat_q[1:0])) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        idx_d = '0;
                    end
                end
                if (bus.stop) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.found     = found_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Self-checking bench for pattern_match_ctrl: directed scenarios plus random traffic,
// compared every cycle against a symbol-progress model of the matching rules.
module tb_pattern_match_ctrl;

    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;
    localparam logic [2*PAT_LEN-1:0] PAT_A = 8'b11_10_01_00;
    localparam logic [2*PAT_LEN-1:0] PAT_B = 8'b00_01_10_11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pattern_match_ctrl_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus ();

    pattern_match_ctrl #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int found_seen = 0;
    int done_seen  = 0;

    int         m_phase;
    int         m_idx;
    int         m_cnt;
    logic [1:0] m_pat [PAT_LEN];
    logic       m_found;
    logic       m_done;

    logic [1:0] stream_q [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_idx counts pattern symbols matched so far; a miss restarts from symbol 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_idx   = 0;
            m_cnt   = 0;
            m_found = 1'b0;
            m_done  = 1'b0;
            for (int i = 0; i < PAT_LEN; i++) m_pat[i] = 2'b00;
        end else begin
            m_found = 1'b0;
            m_done  = 1'b0;
            case (m_phase)
                0: begin
                    if (bus.start) begin
                        for (int i = 0; i < PAT_LEN; i++) m_pat[i] = bus.pattern[2*i +: 2];
                        m_cnt   = 0;
                        m_idx   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (bus.in_valid) begin
                        if (bus.in_sym == m_pat[m_idx]) begin
                            m_idx++;
                            if (m_idx == PAT_LEN) begin
                                m_idx   = 0;
                                m_found = 1'b1;
                                if (m_cnt < CNT_SAT) m_cnt++;
                            end
                        end else begin
                            m_idx = (bus.in_sym == m_pat[0]) ? 1 : 0;
                        end
                    end
                    if (bus.stop) begin
                        m_phase = 2;
                        m_done  = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #2;
        checkOutput("in_ready",  {31'b0, bus.in_ready}, {31'b0, m_phase == 1});
        checkOutput("busy",      {31'b0, bus.busy},     {31'b0, m_phase != 0});
        checkOutput("found",     {31'b0, bus.found},    {31'b0, m_found});
        checkOutput("done",      {31'b0, bus.done},     {31'b0, m_done});
        checkOutput("match_cnt", 32'(bus.match_cnt),    32'(m_cnt));
        found_seen += int'(bus.found);
        done_seen  += int'(bus.done);
    end

    task automatic applyStimulus(input logic s, input logic st, input logic v, input logic [1:0] sym);
        bus.start    = s;
        bus.stop     = st;
        bus.in_valid = v;
        bus.in_sym   = sym;
        @(negedge clk);
    endtask

    task automatic begin_run(input logic [2*PAT_LEN-1:0] p);
        bus.pattern = p;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        bus.pattern = (2*PAT_LEN)'($urandom);
    endtask

    task automatic play_stream(input int gap, input bit stop_last);
        for (int i = 0; i < stream_q.size(); i++) begin
            applyStimulus(1'b0, stop_last && (i == stream_q.size() - 1), 1'b1, stream_q[i]);
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom));
        end
        if (!stop_last) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic expect_run(input string name, input int f0, input int d0,
                              input int exp_found, input int exp_cnt, input int exp_done);
        checkOutput({name, "_found_pulses"}, 32'(found_seen - f0), 32'(exp_found));
        checkOutput({name, "_done_pulses"},  32'(done_seen - d0),  32'(exp_done));
        checkOutput({name, "_match_cnt"},    32'(bus.match_cnt),   32'(exp_cnt));
        checkOutput({name, "_model_cnt"},    32'(m_cnt),           32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string name);
        checkOutput({name, "_in_ready"},  {31'b0, bus.in_ready}, 32'd0);
        checkOutput({name, "_busy"},      {31'b0, bus.busy},     32'd0);
        checkOutput({name, "_found"},     {31'b0, bus.found},    32'd0);
        checkOutput({name, "_done"},      {31'b0, bus.done},     32'd0);
        checkOutput({name, "_match_cnt"}, 32'(bus.match_cnt),    32'd0);
    endtask

    initial begin
        int f0;
        int d0;
        logic [2*PAT_LEN-1:0] p;

        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sym   = 2'b00;
        bus.pattern  = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic match");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        stream_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        play_stream(0, 1'b0);
        expect_run("basic", f0, d0, 1, 1, 1);

        $display("[TB] mismatch restart");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        stream_q = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        play_stream(0, 1'b0);
        expect_run("restart", f0, d0, 1, 1, 1);

        $display("[TB] throttled back-to-back");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        stream_q = {};
        for (int r = 0; r < 3; r++) for (int s = 0; s < PAT_LEN; s++) stream_q.push_back(2'(s));
        play_stream(1, 1'b0);
        expect_run("throttle", f0, d0, 3, 3, 1);

        $display("[TB] saturation with stop on final accept");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        stream_q = {};
        for (int r = 0; r < 5; r++) for (int s = 0; s < PAT_LEN; s++) stream_q.push_back(2'(s));
        play_stream(0, 1'b1);
        expect_run("saturate", f0, d0, 5, 3, 1);

        $display("[TB] ignored controls");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        bus.pattern = '1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        stream_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        play_stream(0, 1'b0);
        expect_run("recapture", f0, d0, 1, 1, 1);
        d0 = done_seen;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        checkOutput("idle_stop_done", 32'(done_seen - d0), 32'd0);
        checkOutput("idle_stop_busy", {31'b0, bus.busy},   32'd0);

        $display("[TB] reset mid-run");
        f0 = found_seen; d0 = done_seen;
        begin_run(PAT_A);
        stream_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        foreach (stream_q[i]) applyStimulus(1'b0, 1'b0, 1'b1, stream_q[i]);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
        checkOutput("prereset_cnt", 32'(bus.match_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        checkOutput("abort_done", 32'(done_seen - d0), 32'd0);
        bus.pattern = PAT_B;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        stream_q = '{2'd3, 2'd2, 2'd1, 2'd0};
        play_stream(0, 1'b0);
        expect_run("post_reset", f0, d0, 2, 1, 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < PAT_LEN; i++) p[2*i +: 2] = 2'($urandom_range(1));
            bus.pattern = p;
            if (c == 300) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            applyStimulus($urandom_range(3) == 0, $urandom_range(19) == 0,
                          $urandom_range(9) < 7,
                          ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'($urandom_range(1)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_match_ctrl.md
PATTERN_MATCH_CTRL -- requirements
Module: pattern_match_ctrl

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, giving the number of 2-bit symbols in the pattern (legal range 2..8).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the match counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit, which begins a run; it is honoured only in IDLE.
REQ-006 The block SHALL have port pattern, input, 2*PAT_LEN bits, the expected symbols; pattern[1:0] is symbol 0 (first expected).
REQ-007 The block SHALL have port stop, input, 1 bit, which ends a run; it is honoured only in RUN.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the source offers in_sym.
REQ-009 The block SHALL have port in_sym, input, 2 bits, the stream symbol.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_sym this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit, high in RUN and DONE.
REQ-012 The block SHALL have port found, output, 1 bit, a one-cycle pulse per complete pattern match.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits, the count of matches in the current or last run.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a run.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL capture pattern into an internal register, clear match_cnt and idx, and go to RUN on the next edge.
REQ-017 The pattern input SHALL be ignored outside the capture cycle.
REQ-018 in_ready SHALL equal 1 exactly when the state is RUN; it is a registered state decode and does not depend on in_valid.
REQ-019 An accept SHALL occur only on a cycle with in_valid=1 and in_ready=1; no other cycle changes idx.
REQ-020 Each accept SHALL compare in_sym against captured symbol[idx] using a 2-bit equality compare.
REQ-021 On an equal compare with idx<PAT_LEN-1, idx SHALL increment.
REQ-022 On an equal compare with idx=PAT_LEN-1, idx SHALL become 0, found SHALL pulse high in the next cycle, and match_cnt SHALL increment on the same edge (matches are non-overlapping).
REQ-023 On an unequal compare with idx>0, in_sym SHALL be re-compared against symbol 0 in the same cycle; idx SHALL become 1 if equal, else 0.
REQ-024 On an unequal compare with idx=0, idx SHALL remain 0.
REQ-025 match_cnt SHALL saturate at 2^CNT_W-1; found still pulses while saturated.
REQ-026 stop=1 in RUN SHALL move the FSM to DONE on the next edge.
REQ-027 An accept in the same cycle as stop SHALL still be processed, including any found pulse and match_cnt increment.
REQ-028 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-029 match_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-030 start asserted in RUN or DONE SHALL be ignored; stop asserted in IDLE or DONE SHALL be ignored.
REQ-031 All outputs SHALL be registered, except in_ready and busy, which are direct decodes of the state register.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, idx=0, the captured pattern to 0, in_ready=0, busy=0, found=0, done=0 and match_cnt=0, regardless of clk.
REQ-033 Reset asserted mid-run SHALL abort the run with no found or done pulse.
REQ-034 After rst_n deasserts, the first edge SHALL see IDLE, and start is honoured on that edge.

Verification
REQ-035 Basic match: pattern=8'b11_10_01_00, start, stream 00,01,10,11, then stop -> one found pulse on the cycle after the 11 accept; match_cnt=1; done pulses once.
REQ-036 Mismatch restart: same pattern, stream 00,00,01,10,11 -> the second 00 leaves idx=1; exactly one found pulse, after the 11 accept; match_cnt=1.
REQ-037 Back-to-back and throttling: stream the pattern 3 times with in_valid toggled on alternate cycles -> three found pulses; idle cycles do not advance idx; match_cnt=3.
REQ-038 Saturation and stop race: CNT_W=2, 5 consecutive matches, with stop asserted on the final accept -> 5 found pulses; match_cnt=3; DONE follows.
REQ-039 Reset mid-run: assert rst_n=0 with idx=2 -> all outputs 0 immediately; after release, start with a new pattern, and a full match gives match_cnt=1.
REQ-040 Ignored controls: start during RUN does not recapture the pattern; stop in IDLE produces no done pulse; in_ready=0 in IDLE and DONE.
